// File: rtl/data_ram_pkg.sv
// Shared types and lane-steering helpers for the data_ram responder.
// Optional write-alignment checking is enabled with DMEM_ALIGN_CHK_EN.
package data_ram_pkg;

    localparam int REG_BUS_W = 32;
    localparam int CNT_W     = 4;

    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;

    typedef logic [REG_BUS_W-1:0] reg_bus_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

    // Store code 3 falls into the default arm and behaves as a word store.
    function automatic logic [3:0] lane_be(input logic [1:0] st, input logic [1:0] a);
        logic [3:0] be;
        case (st)
            ST_SB:   be = 4'b0001 << a;
            ST_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic reg_bus_t lane_data(input logic [1:0] st, input reg_bus_t wd);
        reg_bus_t d;
        case (st)
            ST_SB:   d = {4{wd[7:0]}};
            ST_SH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] a);
        logic m;
        case (st)
            ST_SB:   m = 1'b0;
            ST_SH:   m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// Mem-stage to data RAM request/response bundle.
// The misalign response exists only when DMEM_ALIGN_CHK_EN is defined.
interface data_ram_if;
    import data_ram_pkg::*;

    logic       ram_wreg;
    reg_bus_t   ram_waddr;
    reg_bus_t   ram_wdata;
    logic [1:0] st_type;
    logic       rd_req;
    reg_bus_t   raddr;
    logic       req_ready;
    reg_bus_t   rdata;
    logic       rdata_valid;
    logic       stall_req;
`ifdef DMEM_ALIGN_CHK_EN
    logic       misalign;

    modport master (
        output ram_wreg, ram_waddr, ram_wdata, st_type, rd_req, raddr,
        input  req_ready, rdata, rdata_valid, stall_req, misalign
    );
    modport slave (
        input  ram_wreg, ram_waddr, ram_wdata, st_type, rd_req, raddr,
        output req_ready, rdata, rdata_valid, stall_req, misalign
    );
`else
    modport master (
        output ram_wreg, ram_waddr, ram_wdata, st_type, rd_req, raddr,
        input  req_ready, rdata, rdata_valid, stall_req
    );
    modport slave (
        input  ram_wreg, ram_waddr, ram_wdata, st_type, rd_req, raddr,
        output req_ready, rdata, rdata_valid, stall_req
    );
`endif

endinterface

// File: rtl/data_ram_dmem_array.sv
// DEPTH x 32 storage: byte-enabled synchronous write, combinational read.
module data_ram_dmem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_widx,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_ridx,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Byte-lane write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/data_ram.sv
// Data-memory responder with programmable wait states and pipeline stall.
// Define DMEM_ALIGN_CHK_EN to flag and suppress misaligned half/word stores.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    data_ram_if.slave    bus
);

    localparam bit              NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] WAIT_LOAD = NO_WAIT ? {CNT_W{1'b0}} : CNT_W'(WAIT_CYCLES - 1);

    dmem_state_e       r_state, w_next_state;
    logic [CNT_W-1:0]  r_cnt, w_next_cnt;
    logic              r_rd_pend, w_next_rd_pend;
    logic              r_op_wr, w_next_op_wr;
    logic              w_accept;
    logic [ADDR_W+1:0] r_waddr, r_raddr;
    reg_bus_t          r_wdata;
    logic [1:0]        r_st_type;
    reg_bus_t          r_rdata;
    logic              r_rdata_valid;

    logic [ADDR_W+1:0] w_cur_waddr, w_cur_raddr;
    reg_bus_t          w_cur_wdata;
    logic [1:0]        w_cur_st;
    logic              w_enter_resp, w_wr_commit, w_rd_commit, w_misaligned, w_array_we;
    reg_bus_t          w_arr_rdata;

    // Next-state, counter and pending-read control.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_op_wr   = r_op_wr;
        w_next_rd_pend = r_rd_pend;
        w_accept       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ram_wreg || bus.rd_req) begin
                    w_accept       = 1'b1;
                    w_next_op_wr   = bus.ram_wreg;
                    w_next_rd_pend = bus.ram_wreg && bus.rd_req;
                    w_next_cnt     = WAIT_LOAD;
                    w_next_state   = NO_WAIT ? S_RESP : S_WAIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                // A write that arrived with a read serves the read next.
                if (r_op_wr && r_rd_pend) begin
                    w_next_op_wr   = 1'b0;
                    w_next_rd_pend = 1'b0;
                    w_next_cnt     = WAIT_LOAD;
                    w_next_state   = NO_WAIT ? S_RESP : S_WAIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so use live inputs.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_cur_waddr = bus.ram_waddr[ADDR_W+1:0];
            w_cur_raddr = bus.raddr[ADDR_W+1:0];
            w_cur_wdata = bus.ram_wdata;
            w_cur_st    = bus.st_type;
        end else begin
            w_cur_waddr = r_waddr;
            w_cur_raddr = r_raddr;
            w_cur_wdata = r_wdata;
            w_cur_st    = r_st_type;
        end
    end

    assign w_enter_resp = (w_next_state == S_RESP);
    assign w_wr_commit  = w_enter_resp && w_next_op_wr;
    assign w_rd_commit  = w_enter_resp && !w_next_op_wr;
    assign w_misaligned = is_misaligned(w_cur_st, w_cur_waddr[1:0]);

`ifdef DMEM_ALIGN_CHK_EN
    assign w_array_we = w_wr_commit && rst && !w_misaligned;
`else
    assign w_array_we = w_wr_commit && rst;
`endif

    data_ram_dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_array_we),
        .i_be    (lane_be(w_cur_st, w_cur_waddr[1:0])),
        .i_widx  (w_cur_waddr[ADDR_W+1:2]),
        .i_wdata (lane_data(w_cur_st, w_cur_wdata)),
        .i_ridx  (w_cur_raddr[ADDR_W+1:2]),
        .o_rdata (w_arr_rdata)
    );

    // State, captured request and registered read response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= {CNT_W{1'b0}};
            r_rd_pend     <= 1'b0;
            r_op_wr       <= 1'b0;
            r_waddr       <= {(ADDR_W+2){1'b0}};
            r_raddr       <= {(ADDR_W+2){1'b0}};
            r_wdata       <= {REG_BUS_W{1'b0}};
            r_st_type     <= 2'b00;
            r_rdata       <= {REG_BUS_W{1'b0}};
            r_rdata_valid <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_rd_pend     <= w_next_rd_pend;
            r_op_wr       <= w_next_op_wr;
            r_rdata_valid <= w_rd_commit;
            if (w_accept) begin
                r_waddr   <= bus.ram_waddr[ADDR_W+1:0];
                r_raddr   <= bus.raddr[ADDR_W+1:0];
                r_wdata   <= bus.ram_wdata;
                r_st_type <= bus.st_type;
            end
            if (w_rd_commit) begin
                r_rdata <= w_arr_rdata >> {w_cur_raddr[1:0], 3'b000};
            end
        end
    end

`ifdef DMEM_ALIGN_CHK_EN
    logic r_misalign;

    // One-cycle flag aligned with the suppressed write's RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_wr_commit && w_misaligned;
        end
    end

    assign bus.misalign = r_misalign;
`endif

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.stall_req   = ((r_state == S_IDLE) && (bus.rd_req || bus.ram_wreg))
                           || (r_state == S_WAIT)
                           || ((r_state == S_RESP) && r_op_wr && r_rd_pend);

endmodule

// File: tb/tb_data_ram.sv
// Directed scoreboard bench for data_ram; zero wait states when DMEM_ALIGN_CHK_EN is set.
module tb_data_ram;
    import data_ram_pkg::*;

`ifdef DMEM_ALIGN_CHK_EN
    localparam int TB_W = 0;
`else
    localparam int TB_W = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_ram_if bus ();

    data_ram #(
        .DEPTH       (1024),
        .ADDR_W      (10),
        .WAIT_CYCLES (TB_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    int          mis_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ram_wreg  = 1'b0;
        bus.rd_req    = 1'b0;
        bus.ram_waddr = 32'h0;
        bus.ram_wdata = 32'h0;
        bus.st_type   = 2'd0;
        bus.raddr     = 32'h0;
    endtask

    // Drive one request, hold it while stalled, and score any read response.
    task automatic issue(input logic wr, input logic rd, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [1:0] st,
                         input logic [31:0] ra, input logic [31:0] exp_rd, input string tag);
        int          cyc;
        int          nvalid;
        logic [31:0] e;
        @(negedge clk);
        bus.ram_wreg  = wr;
        bus.rd_req    = rd;
        bus.ram_waddr = wa;
        bus.ram_wdata = wd;
        bus.st_type   = st;
        bus.raddr     = ra;
        if (rd) sb_q.push_back(exp_rd);
        #1;
        chk({tag, "_stall_acc"}, {31'h0, bus.stall_req}, 32'h1);
        cyc      = 0;
        nvalid   = 0;
        mis_seen = 0;
        do begin
            @(negedge clk);
            cyc++;
`ifdef DMEM_ALIGN_CHK_EN
            if (bus.misalign === 1'b1) mis_seen = cyc;
`endif
            if (bus.rdata_valid === 1'b1) begin
                nvalid++;
                chk({tag, "_stall_at_valid"}, {31'h0, bus.stall_req}, 32'h0);
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++;
                    $error("FAIL %s_sb_empty: observed unexpected rdata_valid, expected none", tag);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk({tag, "_rdata"}, bus.rdata, e);
                end
            end
        end while (bus.stall_req === 1'b1 && cyc < 40);
        chk({tag, "_cycles"}, cyc, (wr && rd) ? 32'(2 * (1 + TB_W)) : 32'(1 + TB_W));
        chk({tag, "_nvalid"}, nvalid, {31'h0, rd});
        idle_inputs();
        @(negedge clk);
        chk({tag, "_ready_after"}, {31'h0, bus.req_ready}, 32'h1);
        chk({tag, "_valid_pulse"}, {31'h0, bus.rdata_valid}, 32'h0);
`ifdef DMEM_ALIGN_CHK_EN
        chk({tag, "_mis_pulse"}, {31'h0, bus.misalign}, 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        bus.rd_req = 1'b1;
        rst        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_stall_follows", {31'h0, bus.stall_req}, 32'h1);
        chk("rst_valid", {31'h0, bus.rdata_valid}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        bus.rd_req = 1'b0;
        #1;
        chk("rst_stall_idle", {31'h0, bus.stall_req}, 32'h0);
        rst = 1'b1;

        // Word store and read back.
        issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, ST_SW, 32'h0, 32'h0, "sw10");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h10, 32'hDEADBEEF, "rd10_a");

        // Byte store, right-aligned reads.
        issue(1'b1, 1'b0, 32'h11, 32'h000000AA, ST_SB, 32'h0, 32'h0, "sb11");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h10, 32'hDEADAAEF, "rd10_b");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h11, 32'h00DEADAA, "rd11");

        // Half store to the upper half.
        issue(1'b1, 1'b0, 32'h12, 32'h00001234, ST_SH, 32'h0, 32'h0, "sh12");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h12, 32'h00001234, "rd12");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h10, 32'h1234AAEF, "rd10_c");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h13, 32'h00000012, "rd13");

        // Upper address bits ignored; store code 3 acts as a word store.
        issue(1'b1, 1'b0, 32'h1040, 32'hCAFEF00D, 2'd3, 32'h0, 32'h0, "sw1040");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h40, 32'hCAFEF00D, "rd40_wrap");

        // Simultaneous write and read of the same word: write first.
        issue(1'b1, 1'b1, 32'h20, 32'h11223344, ST_SW, 32'h20, 32'h11223344, "swrd20");
        issue(1'b1, 1'b0, 32'h23, 32'h00000055, ST_SB, 32'h0, 32'h0, "sb23");
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h20, 32'h55223344, "rd20");

        // Reset in the middle of a write.
        issue(1'b1, 1'b0, 32'h30, 32'h00000005, ST_SW, 32'h0, 32'h0, "sw30");
        @(negedge clk);
        bus.ram_wreg  = 1'b1;
        bus.ram_waddr = 32'h30;
        bus.ram_wdata = 32'h00000009;
        bus.st_type   = ST_SW;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("mid_rst_stall", {31'h0, bus.stall_req}, 32'h0);
        chk("mid_rst_valid", {31'h0, bus.rdata_valid}, 32'h0);
        chk("mid_rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        // Without wait states the write commits on acceptance, before reset can drop it.
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h30, (TB_W == 0) ? 32'h9 : 32'h5, "rd30");

        // Word store to a non-word-aligned address.
        issue(1'b1, 1'b0, 32'h13, 32'hFFFFFFFF, ST_SW, 32'h0, 32'h0, "sw13");
`ifdef DMEM_ALIGN_CHK_EN
        chk("sw13_misalign_cycle", mis_seen, 32'd1);
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h10, 32'h1234AAEF, "rd10_unchanged");
`else
        issue(1'b0, 1'b1, 32'h0, 32'h0, ST_SB, 32'h10, 32'hFFFFFFFF, "rd10_sw13");
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
